// File: rtl/ring_freq_meter.sv
// ring_freq_meter: selects one free-running ring oscillator output, brings it
// into the clk domain and counts its rising edges over a gate window of
// 2^g clock cycles. The saturating result is held for byte-wide readout.
//
//   state  | meaning
//   -------+-------------------------------------------------------------
//   IDLE   | waiting for start; last result held on count/overflow
//   SETTLE | 3 cycles: new mux path flushes, prev loads, rises ignored
//   COUNT  | 2^g cycles of counting rising edges of the selected ring
//   DONE   | one cycle: done pulse, count/overflow valid
module ring_freq_meter #(
    parameter int NRINGS   = 8,
    parameter int CNT_W    = 16,
    parameter int MAX_LOG2 = 20,
    localparam int SEL_W   = (NRINGS > 1) ? $clog2(NRINGS) : 1,
    localparam int TMR_W   = MAX_LOG2 + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NRINGS-1:0] ring_in,
    input  logic [SEL_W-1:0]  sel,
    input  logic [4:0]        gate_log2,
    input  logic              start,
    input  logic [1:0]        byte_sel,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  count,
    output logic              overflow,
    output logic [7:0]        byte_out
);

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        COUNT,
        DONE
    } state_t;

    state_t              state;
    logic [NRINGS-1:0]   sync1;
    logic [NRINGS-1:0]   sync2;
    logic                prev;
    logic [SEL_W-1:0]    sel_q;
    logic [4:0]          g_q;
    logic [1:0]          settle_cnt;
    logic [TMR_W-1:0]    timer;
    logic [CNT_W-1:0]    counter;
    logic                ov_flag;

    logic                sync_sel;
    logic                rise;
    logic [4:0]          g_clamp;
    logic [TMR_W-1:0]    timer_load;
    logic [CNT_W-1:0]    cnt_next;
    logic                ov_next;
    logic [31:0]         count_ext;

    assign sync_sel   = sync2[sel_q];
    assign rise       = sync_sel & ~prev;
    assign g_clamp    = (gate_log2 > 5'(MAX_LOG2)) ? 5'(MAX_LOG2) : gate_log2;
    assign timer_load = (TMR_W'(1) << g_q) - TMR_W'(1);

    // Two-flop synchronizer on every ring bit, plus the edge-detect flop on
    // the selected bit; the whole bus stays synchronized so a new sel only
    // needs the mux path to settle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= '0;
            sync2 <= '0;
            prev  <= 1'b0;
        end else begin
            sync1 <= ring_in;
            sync2 <= sync1;
            prev  <= sync_sel;
        end
    end

    // Saturating increment; an increment attempted at full scale flags overflow.
    always_comb begin
        cnt_next = counter;
        ov_next  = ov_flag;
        if (rise) begin
            if (&counter) begin
                ov_next = 1'b1;
            end else begin
                cnt_next = counter + CNT_W'(1);
            end
        end
    end

    // Measurement sequencer with registered busy/done/count/overflow.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            sel_q      <= '0;
            g_q        <= '0;
            settle_cnt <= '0;
            timer      <= '0;
            counter    <= '0;
            ov_flag    <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            count      <= '0;
            overflow   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        sel_q      <= sel;
                        g_q        <= g_clamp;
                        counter    <= '0;
                        ov_flag    <= 1'b0;
                        settle_cnt <= '0;
                        busy       <= 1'b1;
                        state      <= SETTLE;
                    end
                end
                SETTLE: begin
                    if (settle_cnt == 2'd2) begin
                        timer <= timer_load;
                        state <= COUNT;
                    end else begin
                        settle_cnt <= settle_cnt + 2'd1;
                    end
                end
                COUNT: begin
                    counter <= cnt_next;
                    ov_flag <= ov_next;
                    if (timer == '0) begin
                        count    <= cnt_next;
                        overflow <= ov_next;
                        done     <= 1'b1;
                        state    <= DONE;
                    end else begin
                        timer <= timer - TMR_W'(1);
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

    // Byte readout; bytes beyond the result width read as zero.
    always_comb begin
        count_ext = 32'(count);
        byte_out  = count_ext[{byte_sel, 3'b000} +: 8];
    end

endmodule

// File: tb/tb_ring_freq_meter.sv
// Bench for ring_freq_meter. Rings are driven on the falling clock edge with
// programmable half-periods (or random levels). Every rising-edge sample of
// the ring bus is logged; the expected count is the number of 0->1
// transitions of the selected ring across the gate window, shifted by the
// synchronizer/edge-flop latency, then saturated at the counter width.
// Instantiated with a reduced counter width and gate exponent so the
// saturation and clamp cases fit a short run.
module tb_ring_freq_meter;

    localparam int NR = 8;
    localparam int CW = 12;
    localparam int ML = 14;

    logic          clk = 1'b0;
    logic          rst;
    logic [NR-1:0] ring_in = '0;
    logic [2:0]    sel;
    logic [4:0]    gate_log2;
    logic          start;
    logic [1:0]    byte_sel;
    logic          busy;
    logic          done;
    logic [CW-1:0] count;
    logic          overflow;
    logic [7:0]    byte_out;

    int checks = 0;
    int errors = 0;

    int half [NR] = '{default: 0};
    int hcnt [NR] = '{default: 0};
    logic [NR-1:0] hist [0:131071];
    int edge_n = 0;
    int last_cnt = 0;

    ring_freq_meter #(
        .NRINGS   (NR),
        .CNT_W    (CW),
        .MAX_LOG2 (ML)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .ring_in   (ring_in),
        .sel       (sel),
        .gate_log2 (gate_log2),
        .start     (start),
        .byte_sel  (byte_sel),
        .busy      (busy),
        .done      (done),
        .count     (count),
        .overflow  (overflow),
        .byte_out  (byte_out)
    );

    always #5 clk = ~clk;

    // Ring generators: half==0 static, 255 random level, else toggle every half negedges.
    always @(negedge clk) begin
        for (int i = 0; i < NR; i++) begin
            if (half[i] == 255) begin
                ring_in[i] = 1'($urandom);
            end else if (half[i] > 0) begin
                hcnt[i]++;
                if (hcnt[i] >= half[i]) begin
                    ring_in[i] = ~ring_in[i];
                    hcnt[i] = 0;
                end
            end
        end
    end

    // Log what the DUT sees at each rising edge.
    always @(posedge clk) begin
        edge_n++;
        hist[edge_n] = ring_in;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expd);
        checks++;
        if (obs !== expd) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, obs, expd);
        end
    endtask

    // Rising transitions of ring s as seen through the 2-flop sync and edge
    // flop during the COUNT cycles that follow a start sampled at edge k.
    function automatic int model_rises(input int s, input int k, input int g);
        int n = 0;
        for (int e = k + 4; e <= k + 3 + (1 << g); e++)
            if (hist[e-2][s] && !hist[e-3][s]) n++;
        return n;
    endfunction

    task automatic measure(input int s, input int g, input bit disturb);
        int gc, k, win, n, sat, exp_cnt, exp_ov;
        bit got, busy_drop, extra;
        gc = (g > ML) ? ML : g;
        win = 1 << gc;
        sel = 3'(s);
        gate_log2 = 5'(g);
        start = 1'b1;
        @(posedge clk); #1;
        k = edge_n;
        start = 1'b0;
        check("busy_rise", busy, 1);
        got = 0;
        busy_drop = 0;
        for (int i = 1; i <= win + 20; i++) begin
            @(posedge clk); #1;
            if (disturb && i == 20) begin
                start = 1'b1;
                sel = 3'd5;
                gate_log2 = 5'd0;
            end
            if (disturb && i == 21) start = 1'b0;
            if (done) begin
                got = 1;
                break;
            end
            if (!busy) busy_drop = 1;
        end
        start = 1'b0;
        check("done_seen", got, 1);
        check("done_edge", edge_n - k, 3 + win);
        check("busy_in_done", busy, 1);
        check("busy_held", busy_drop, 0);
        n = model_rises(s, k, gc);
        sat = (1 << CW) - 1;
        exp_cnt = (n > sat) ? sat : n;
        exp_ov = (n > sat) ? 1 : 0;
        last_cnt = exp_cnt;
        check("count", count, exp_cnt);
        check("overflow", overflow, exp_ov);
        extra = 0;
        repeat (8) begin
            @(posedge clk); #1;
            if (busy || done) extra = 1;
        end
        check("idle_after", extra, 0);
        check("count_held", count, exp_cnt);
        for (int b = 0; b < 4; b++) begin
            byte_sel = 2'(b);
            #1;
            check("byte_out", byte_out, (exp_cnt >> (8 * b)) & 255);
        end
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        sel = '0;
        gate_log2 = '0;
        byte_sel = 2'd1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_count", count, 0);
        check("rst_overflow", overflow, 0);
        check("rst_byte_out", byte_out, 0);
        rst = 1'b0;
        repeat (5) @(posedge clk);
        #1;

        // Basic: period 4, g=6 -> 16
        half[2] = 2;
        measure(2, 6, 0);
        check("basic_16", count, 16);

        // Readout: period 4, g=12 -> 0x400
        measure(2, 12, 0);
        check("readout_400", count, 12'h400);

        // Saturation: period 2, g=14 -> 8192 rises into a 12-bit counter
        half[3] = 1;
        measure(3, 14, 0);
        check("sat_count", count, 12'hFFF);
        check("sat_overflow", overflow, 1);

        // Clamp: static ring, g=31 clamped to ML
        half[4] = 0;
        measure(4, 31, 0);
        check("clamp_count", count, 0);

        // Ignored start/sel/gate changes mid-COUNT
        half[5] = 1;
        measure(2, 6, 1);
        check("ignored_16", count, 16);

        // Reset 20 cycles into COUNT
        sel = 3'd2;
        gate_log2 = 5'd6;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (23) @(posedge clk);
        #1;
        check("pre_rst_busy", busy, 1);
        rst = 1'b1;
        #1;
        check("mid_rst_busy", busy, 0);
        check("mid_rst_count", count, 0);
        check("mid_rst_done", done, 0);
        check("mid_rst_overflow", overflow, 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        measure(2, 6, 0);
        check("after_rst_16", count, 16);

        // Randomized rings, selection and gate
        repeat (8) begin
            int pick;
            for (int i = 0; i < NR; i++) begin
                pick = $urandom_range(0, 5);
                case (pick)
                    0: half[i] = 0;
                    1: half[i] = 1;
                    2: half[i] = 2;
                    3: half[i] = 3;
                    4: half[i] = 5;
                    default: half[i] = 255;
                endcase
            end
            repeat (4) @(posedge clk);
            #1;
            measure($urandom_range(0, NR - 1), $urandom_range(0, 9), 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
